// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_WAIT   = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } fetch_state_e;

   localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
   localparam logic [15:0] PC_INC          = 16'd2;

endpackage

// File: rtl/fetch_unit_pc_incr.sv
// Combinational next-sequential-PC adder (wraps modulo 2^16).
module pc_incr
   import fetch_pkg::*;
(
   input  logic [15:0] pc_in,
   output logic [15:0] pc_out
);

   assign pc_out = pc_in + PC_INC;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory handshake FSM, one-word hold buffer, IF/ID register.
// Optional delivered-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF,
   parameter logic [15:0] RST_PC      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_current,
   output logic [15:0] pc_new,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_data,
   output logic        ifid_valid,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus2,
   output logic        halted,
   output logic [15:0] fetch_count
);

   fetch_state_e state_q, state_d;
   logic [15:0]  addr_q, addr_d;
   logic [15:0]  hold_q, hold_d;
   logic         drop_q, drop_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [15:0]  ifid_instr_q, ifid_instr_d;
   logic [15:0]  ifid_pc_plus2_q, ifid_pc_plus2_d;

   logic         deliver;
   logic [15:0]  dlv_word;
   logic [15:0]  dlv_addr;
   logic [15:0]  dlv_addr_p2;

   pc_incr u_pc_incr (
      .pc_in  (dlv_addr),
      .pc_out (dlv_addr_p2)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      hold_d          = hold_q;
      drop_d          = drop_q;
      ifid_valid_d    = stall ? ifid_valid_q : 1'b0;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus2_d = ifid_pc_plus2_q;
      imem_req        = 1'b0;
      imem_addr       = pc_current;
      pc_new          = pc_current;
      deliver         = 1'b0;
      dlv_word        = imem_data;
      dlv_addr        = pc_current;

      case (state_q)
         S_FETCH: begin
            imem_req = !stall;
            if (!stall) begin
               if (imem_ready) begin
                  deliver = 1'b1;
               end else begin
                  addr_d  = pc_current;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            imem_req  = 1'b1;
            imem_addr = addr_q;
            dlv_addr  = addr_q;
            if (imem_ready) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_FETCH;
               end else if (!stall) begin
                  deliver = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  hold_d  = imem_data;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            dlv_addr = addr_q;
            dlv_word = hold_q;
            if (!stall) begin
               deliver = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: ;
      endcase

      // A halt word still enters IF/ID but freezes the PC at its own address.
      if (deliver) begin
         ifid_valid_d    = 1'b1;
         ifid_instr_d    = dlv_word;
         ifid_pc_plus2_d = dlv_addr_p2;
         if (dlv_word[15:12] == HALT_OPCODE) begin
            state_d = S_HALTED;
         end else begin
            pc_new = dlv_addr_p2;
         end
      end

      if (branch_taken) begin
         pc_new          = branch_target;
         ifid_valid_d    = 1'b0;
         ifid_instr_d    = ifid_instr_q;
         ifid_pc_plus2_d = ifid_pc_plus2_q;
         hold_d          = 16'h0000;
         // An in-flight read must still be drained; mark it for discard.
         if (state_q == S_WAIT && !imem_ready) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
         end else begin
            state_d = S_FETCH;
            drop_d  = 1'b0;
         end
      end

      if (rst) begin
         imem_req = 1'b0;
         pc_new   = RST_PC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_FETCH;
         addr_q          <= 16'h0000;
         hold_q          <= 16'h0000;
         drop_q          <= 1'b0;
         ifid_valid_q    <= 1'b0;
         ifid_instr_q    <= 16'h0000;
         ifid_pc_plus2_q <= 16'h0000;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         hold_q          <= hold_d;
         drop_q          <= drop_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_plus2_q <= ifid_pc_plus2_d;
      end
   end

   assign ifid_valid    = ifid_valid_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc_plus2 = ifid_pc_plus2_q;
   assign halted        = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count_q, fetch_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      if (deliver && !branch_taken && fetch_count_q != 16'hFFFF) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_q <= 16'h0000;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the PC register is modelled here as a flop fed by pc_new.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc_current = 16'h0000;
   logic [15:0] pc_new;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        stall;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_data;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        halted;
   logic [15:0] fetch_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .pc_current    (pc_current),
      .pc_new        (pc_new),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_data     (imem_data),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pc_current <= pc_new;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic [15:0] tgt, input logic stl,
                        input logic rdy, input logic [15:0] dat);
      branch_taken  = br;
      branch_target = tgt;
      stall         = stl;
      imem_ready    = rdy;
      imem_data     = dat;
      #1;
   endtask

   task automatic comb_chk(input string tag, input logic req, input logic [15:0] addr,
                           input logic [15:0] pcn);
      chk({tag, ".imem_req"}, {15'b0, imem_req}, {15'b0, req});
      if (req) chk({tag, ".imem_addr"}, imem_addr, addr);
      chk({tag, ".pc_new"}, pc_new, pcn);
   endtask

   task automatic reg_chk(input string tag, input logic v, input logic [15:0] instr,
                          input logic [15:0] pp2, input logic h);
      logic [15:0] cnt_exp;
`ifdef FETCH_PERF_CNT_EN
      cnt_exp = 16'(exp_cnt);
`else
      cnt_exp = 16'h0000;
`endif
      chk({tag, ".ifid_valid"}, {15'b0, ifid_valid}, {15'b0, v});
      chk({tag, ".ifid_instr"}, ifid_instr, instr);
      chk({tag, ".ifid_pc_plus2"}, ifid_pc_plus2, pp2);
      chk({tag, ".halted"}, {15'b0, halted}, {15'b0, h});
      chk({tag, ".fetch_count"}, fetch_count, cnt_exp);
   endtask

   initial begin
      // Reset: a pending branch and an idle memory must not leak through.
      rst = 1'b1;
      drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
      comb_chk("rst", 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();
      reg_chk("rst", 1'b0, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b0;

      // Zero-wait fetch at 0x0010.
      drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
      comb_chk("a_br", 1'b1, 16'h0000, 16'h0010);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
      comb_chk("a_fetch", 1'b1, 16'h0010, 16'h0012);
      tick();
      exp_cnt++;
      reg_chk("a", 1'b1, 16'h1234, 16'h0012, 1'b0);

      // Three wait cycles at 0x0020.
      drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000);
      tick();
      reg_chk("b_br", 1'b0, 16'h1234, 16'h0012, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
         comb_chk($sformatf("b_wait%0d", i), 1'b1, 16'h0020, 16'h0020);
         tick();
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222);
      comb_chk("b_dlv", 1'b1, 16'h0020, 16'h0022);
      tick();
      exp_cnt++;
      reg_chk("b", 1'b1, 16'h2222, 16'h0022, 1'b0);

      // Stall during WAIT, word parked in HOLD for two cycles.
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      comb_chk("c_fetch", 1'b1, 16'h0022, 16'h0022);
      tick();
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333);
      comb_chk("c_wait", 1'b1, 16'h0022, 16'h0022);
      tick();
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'hDEAD);
      comb_chk("c_hold1", 1'b0, 16'h0000, 16'h0022);
      tick();
      reg_chk("c_hold1", 1'b0, 16'h2222, 16'h0022, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      comb_chk("c_hold2", 1'b0, 16'h0000, 16'h0024);
      tick();
      exp_cnt++;
      reg_chk("c", 1'b1, 16'h3333, 16'h0024, 1'b0);

      // Branch while a read is outstanding: the returning word is dropped.
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      tick();
      drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
      comb_chk("d_br", 1'b1, 16'h0024, 16'h0100);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5555);
      comb_chk("d_drop", 1'b1, 16'h0024, 16'h0100);
      tick();
      reg_chk("d_drop", 1'b0, 16'h3333, 16'h0024, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101);
      comb_chk("d_fetch", 1'b1, 16'h0100, 16'h0102);
      tick();
      exp_cnt++;
      reg_chk("d", 1'b1, 16'h0101, 16'h0102, 1'b0);

      // Halt word at 0x0040, then resume via branch to 0x0050.
      drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hF000);
      comb_chk("e_halt", 1'b1, 16'h0040, 16'h0040);
      tick();
      exp_cnt++;
      reg_chk("e_halt", 1'b1, 16'hF000, 16'h0042, 1'b1);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777);
      comb_chk("e_halted", 1'b0, 16'h0000, 16'h0040);
      tick();
      reg_chk("e_halted", 1'b0, 16'hF000, 16'h0042, 1'b1);
      drive(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0000);
      comb_chk("e_br", 1'b0, 16'h0000, 16'h0050);
      tick();
      reg_chk("e_br", 1'b0, 16'hF000, 16'h0042, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111);
      comb_chk("e_resume", 1'b1, 16'h0050, 16'h0052);
      tick();
      exp_cnt++;
      reg_chk("e_resume", 1'b1, 16'h1111, 16'h0052, 1'b0);

      // Wrap at 0xFFFE, then reset in the middle of a WAIT.
      drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0AAA);
      comb_chk("f_wrap", 1'b1, 16'hFFFE, 16'h0000);
      tick();
      exp_cnt++;
      reg_chk("f_wrap", 1'b1, 16'h0AAA, 16'h0000, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      tick();
      rst = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      comb_chk("f_rst", 1'b0, 16'h0000, 16'h0000);
      tick();
      exp_cnt = 0;
      reg_chk("f_rst", 1'b0, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 16'h9999);
      comb_chk("f_stray", 1'b0, 16'h0000, 16'h0000);
      tick();
      reg_chk("f_stray", 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      comb_chk("f_restart", 1'b1, 16'h0000, 16'h0000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
